// File: rtl/uart_bus_master.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : uart_bus_master
// Brief    : Debug bridge turning host UART command frames into bus peek/poke.
// Revision : 1.0
// ============================================================================
module uart_bus_master #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_start,
    input  logic        tx_busy,
    output logic        mem_valid,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        busy
);

    localparam int              TW           = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0]   c_timer_last = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0]   c_timer_max  = {TW{1'b1}};
    localparam logic [7:0]      c_cmd_write  = 8'h57;
    localparam logic [7:0]      c_cmd_read   = 8'h52;
    localparam logic [7:0]      c_ack        = 8'h06;
    localparam logic [7:0]      c_nak        = 8'h15;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_WDATA = 3'd2,
        ST_BUS   = 3'd3,
        ST_RESP  = 3'd4,
        ST_RDATA = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        TX_READY   = 2'd0,
        TX_WAIT_HI = 2'd1,
        TX_WAIT_LO = 2'd2
    } tx_phase_t;

    state_t        r_state,     w_state_nxt;
    tx_phase_t     r_tx_phase,  w_tx_phase_nxt;
    logic          r_is_write,  w_is_write_nxt;
    logic          r_status_ok, w_status_ok_nxt;
    logic [1:0]    r_byte_cnt,  w_byte_cnt_nxt;
    logic [TW-1:0] r_timer,     w_timer_nxt;
    logic [31:0]   r_addr,      w_addr_nxt;
    logic [31:0]   r_wdata,     w_wdata_nxt;
    logic [31:0]   r_rdata,     w_rdata_nxt;
    logic [7:0]    r_tx_data,   w_tx_data_nxt;
    logic          r_tx_start,  w_tx_start_nxt;

    logic [TW-1:0] w_timer_inc;
    logic          w_timer_expired;
    logic [7:0]    w_tx_byte;
    logic          w_tx_done;

    // Gap and bus timers share one saturating counter; it is cleared on every state entry that uses it.
    assign w_timer_inc     = (r_timer == c_timer_max) ? r_timer : r_timer + TW'(1);
    assign w_timer_expired = (r_timer >= c_timer_last);
    assign w_tx_byte       = (r_state == ST_RESP) ? (r_status_ok ? c_ack : c_nak) : r_rdata[31:24];
    assign w_tx_done       = (r_tx_phase == TX_WAIT_LO) && !tx_busy;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_tx_phase  <= TX_READY;
            r_is_write  <= 1'b0;
            r_status_ok <= 1'b0;
            r_byte_cnt  <= 2'd0;
            r_timer     <= '0;
            r_addr      <= 32'h0;
            r_wdata     <= 32'h0;
            r_rdata     <= 32'h0;
            r_tx_data   <= 8'h0;
            r_tx_start  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_tx_phase  <= w_tx_phase_nxt;
            r_is_write  <= w_is_write_nxt;
            r_status_ok <= w_status_ok_nxt;
            r_byte_cnt  <= w_byte_cnt_nxt;
            r_timer     <= w_timer_nxt;
            r_addr      <= w_addr_nxt;
            r_wdata     <= w_wdata_nxt;
            r_rdata     <= w_rdata_nxt;
            r_tx_data   <= w_tx_data_nxt;
            r_tx_start  <= w_tx_start_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_tx_phase_nxt  = r_tx_phase;
        w_is_write_nxt  = r_is_write;
        w_status_ok_nxt = r_status_ok;
        w_byte_cnt_nxt  = r_byte_cnt;
        w_timer_nxt     = r_timer;
        w_addr_nxt      = r_addr;
        w_wdata_nxt     = r_wdata;
        w_rdata_nxt     = r_rdata;
        w_tx_data_nxt   = r_tx_data;
        w_tx_start_nxt  = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (rx_valid && (rx_data == c_cmd_write || rx_data == c_cmd_read)) begin
                    w_is_write_nxt = (rx_data == c_cmd_write);
                    w_byte_cnt_nxt = 2'd0;
                    w_timer_nxt    = '0;
                    w_state_nxt    = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (rx_valid) begin
                    w_addr_nxt     = {r_addr[23:0], rx_data};
                    w_timer_nxt    = '0;
                    w_byte_cnt_nxt = r_byte_cnt + 2'd1;
                    if (r_byte_cnt == 2'd3)
                        w_state_nxt = r_is_write ? ST_WDATA : ST_BUS;
                end else if (w_timer_expired) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_timer_nxt = w_timer_inc;
                end
            end
            ST_WDATA: begin
                if (rx_valid) begin
                    w_wdata_nxt    = {r_wdata[23:0], rx_data};
                    w_timer_nxt    = '0;
                    w_byte_cnt_nxt = r_byte_cnt + 2'd1;
                    if (r_byte_cnt == 2'd3)
                        w_state_nxt = ST_BUS;
                end else if (w_timer_expired) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_timer_nxt = w_timer_inc;
                end
            end
            ST_BUS: begin
                // A late mem_ready coinciding with expiry still wins.
                if (mem_ready) begin
                    w_rdata_nxt     = mem_rdata;
                    w_status_ok_nxt = 1'b1;
                    w_tx_phase_nxt  = TX_READY;
                    w_state_nxt     = ST_RESP;
                end else if (w_timer_expired) begin
                    w_status_ok_nxt = 1'b0;
                    w_tx_phase_nxt  = TX_READY;
                    w_state_nxt     = ST_RESP;
                end else begin
                    w_timer_nxt = w_timer_inc;
                end
            end
            ST_RESP, ST_RDATA: begin
                case (r_tx_phase)
                    TX_READY: begin
                        if (!tx_busy) begin
                            w_tx_start_nxt = 1'b1;
                            w_tx_data_nxt  = w_tx_byte;
                            w_tx_phase_nxt = TX_WAIT_HI;
                        end
                    end
                    TX_WAIT_HI: begin
                        if (tx_busy)
                            w_tx_phase_nxt = TX_WAIT_LO;
                    end
                    TX_WAIT_LO: begin
                        if (!tx_busy)
                            w_tx_phase_nxt = TX_READY;
                    end
                    default: w_tx_phase_nxt = TX_READY;
                endcase

                if (w_tx_done) begin
                    if (r_state == ST_RESP) begin
                        w_byte_cnt_nxt = 2'd0;
                        w_state_nxt    = (r_status_ok && !r_is_write) ? ST_RDATA : ST_IDLE;
                    end else begin
                        w_rdata_nxt    = {r_rdata[23:0], 8'h00};
                        w_byte_cnt_nxt = r_byte_cnt + 2'd1;
                        if (r_byte_cnt == 2'd3)
                            w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign mem_valid = (r_state == ST_BUS);
    assign mem_wstrb = (r_state == ST_BUS && r_is_write) ? 4'hF : 4'h0;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign tx_data   = r_tx_data;
    assign tx_start  = r_tx_start;
    assign busy      = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_bus_master.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_uart_bus_master
// Brief    : Directed self-checking bench with UART TX and bus responder models.
// Revision : 1.0
// ============================================================================
module tb_uart_bus_master;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_busy;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        busy;

    always #5 clk = ~clk;

    uart_bus_master #(.TIMEOUT_CYCLES(TO)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .tx_data   (tx_data),
        .tx_start  (tx_start),
        .tx_busy   (tx_busy),
        .mem_valid (mem_valid),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // UART transmitter model: busy rises the cycle after tx_start and lasts 3 cycles.
    logic [7:0] tx_log[$];
    int         tx_cnt   = 0;
    bit         tx_pend  = 1'b0;
    bit         tx_armed = 1'b1;

    always @(negedge clk) begin
        if (tx_start) begin
            check("tx_start_while_busy", 32'(tx_busy), 32'd0);
            check("tx_start_without_busy_cycle", 32'(tx_armed), 32'd1);
            tx_log.push_back(tx_data);
            tx_armed = 1'b0;
            tx_pend  = 1'b1;
        end else if (tx_pend) begin
            tx_busy = 1'b1;
            tx_cnt  = 3;
            tx_pend = 1'b0;
        end else if (tx_cnt > 0) begin
            tx_cnt--;
            if (tx_cnt == 0) begin
                tx_busy  = 1'b0;
                tx_armed = 1'b1;
            end
        end
    end

    // Bus responder: pulses mem_ready in the resp_delay-th cycle of mem_valid.
    bit          resp_en    = 1'b1;
    int          resp_delay = 3;
    logic [31:0] resp_data  = 32'h0;
    int          vcount     = 0;
    int          last_vlen  = 0;
    int          txn_count  = 0;
    logic [31:0] cap_addr   = 32'h0;
    logic [31:0] cap_wdata  = 32'h0;
    logic [3:0]  cap_wstrb  = 4'h0;

    always @(negedge clk) begin
        if (mem_valid) begin
            vcount++;
            if (vcount == 1) begin
                txn_count++;
                cap_addr  = mem_addr;
                cap_wdata = mem_wdata;
                cap_wstrb = mem_wstrb;
            end
            if (resp_en && vcount == resp_delay) begin
                mem_ready = 1'b1;
                mem_rdata = resp_data;
            end else begin
                mem_ready = 1'b0;
                mem_rdata = 32'h0;
            end
        end else begin
            if (vcount != 0) last_vlen = vcount;
            vcount    = 0;
            mem_ready = 1'b0;
            mem_rdata = 32'h0;
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit gap);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        if (gap) @(negedge clk);
    endtask

    task automatic send_write(input logic [31:0] a, input logic [31:0] d);
        send_byte(8'h57, 1'b1);
        for (int i = 3; i >= 0; i--) send_byte(a[8*i +: 8], 1'b1);
        for (int i = 3; i >= 0; i--) send_byte(d[8*i +: 8], i != 0);
    endtask

    task automatic send_read(input logic [31:0] a);
        send_byte(8'h52, 1'b1);
        for (int i = 3; i >= 0; i--) send_byte(a[8*i +: 8], i != 0);
    endtask

    task automatic wait_idle(input int max, input string tag);
        for (int i = 0; i < max; i++) begin
            if (!busy && !tx_busy && !tx_pend) break;
            @(negedge clk);
        end
        check({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    // Expected bytes packed MSB-first in exp, n of them.
    task automatic check_log(input string tag, input int n, input logic [39:0] exp);
        logic [7:0] got;
        check({tag, "_tx_count"}, 32'(tx_log.size()), 32'(n));
        for (int i = 0; i < n; i++) begin
            got = 8'hxx;
            if (i < tx_log.size()) got = tx_log[i];
            check($sformatf("%s_tx_byte%0d", tag, i), 32'(got), 32'(exp[8*(n-1-i) +: 8]));
        end
    endtask

    int txn_before;

    initial begin
        rx_data   = 8'h00;
        rx_valid  = 1'b0;
        tx_busy   = 1'b0;
        mem_ready = 1'b0;
        mem_rdata = 32'h0;
        reset_n   = 1'b0;
        repeat (3) @(negedge clk);

        check("rst_tx_start",  32'(tx_start),  32'd0);
        check("rst_tx_data",   32'(tx_data),   32'd0);
        check("rst_mem_valid", 32'(mem_valid), 32'd0);
        check("rst_mem_addr",  mem_addr,       32'd0);
        check("rst_mem_wdata", mem_wdata,      32'd0);
        check("rst_mem_wstrb", 32'(mem_wstrb), 32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // Write with 3-cycle responder
        tx_log.delete();
        resp_en = 1'b1; resp_delay = 3;
        send_write(32'h0000_0010, 32'h0000_0041);
        check("wr_valid_rise", 32'(mem_valid), 32'd1);
        check("wr_addr",       mem_addr,       32'h10);
        check("wr_wdata",      mem_wdata,      32'h41);
        check("wr_wstrb",      32'(mem_wstrb), 32'hF);
        wait_idle(200, "wr");
        check("wr_valid_len",  32'(last_vlen), 32'd3);
        check("wr_txn_count",  32'(txn_count), 32'd1);
        check_log("wr", 1, 40'h06);
        check("wr_wstrb_after", 32'(mem_wstrb), 32'd0);
        check("wr_addr_hold",   mem_addr,       32'h10);

        // Read returning DEADBEEF
        tx_log.delete();
        resp_data = 32'hDEAD_BEEF; resp_delay = 2;
        send_read(32'h0000_0008);
        check("rd_valid_rise", 32'(mem_valid), 32'd1);
        check("rd_addr",       mem_addr,       32'h08);
        check("rd_wstrb",      32'(mem_wstrb), 32'h0);
        wait_idle(300, "rd");
        check_log("rd", 5, 40'h06_DE_AD_BE_EF);

        // Read to a silent address
        tx_log.delete();
        resp_en = 1'b0;
        send_read(32'h0000_0044);
        wait_idle(300, "to");
        check("to_valid_len",  32'(last_vlen), 32'(TO));
        check_log("to", 1, 40'h15);
        check("to_mem_valid",  32'(mem_valid), 32'd0);

        // Garbage, partial frame abandoned by gap, then a good read
        tx_log.delete();
        resp_en = 1'b1; resp_delay = 1; resp_data = 32'h1234_5678;
        txn_before = txn_count;
        send_byte(8'h00, 1'b1);
        send_byte(8'hFF, 1'b1);
        check("resync_idle_after_junk", 32'(busy), 32'd0);
        send_byte(8'h57, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        repeat (TO + 9) @(negedge clk);
        check("gap_abort_idle", 32'(busy), 32'd0);
        check("gap_no_bus",     32'(txn_count - txn_before), 32'd0);
        check("gap_no_tx",      32'(tx_log.size()), 32'd0);
        send_read(32'h0000_0020);
        wait_idle(300, "gap_rd");
        check("gap_rd_addr", cap_addr, 32'h20);
        check("gap_rd_txns", 32'(txn_count - txn_before), 32'd1);
        check_log("gap_rd", 5, 40'h06_12_34_56_78);

        // Bytes arriving during RDATA must be ignored
        tx_log.delete();
        resp_data = 32'hA1B2_C3D4;
        txn_before = txn_count;
        send_read(32'h0000_0030);
        for (int i = 0; i < 300 && tx_log.size() < 2; i++) @(negedge clk);
        check("drop_rdata_started", 32'(tx_log.size() >= 2), 32'd1);
        send_byte(8'h57, 1'b1);
        send_byte(8'h52, 1'b1);
        send_byte(8'h57, 1'b1);
        wait_idle(300, "drop");
        check_log("drop", 5, 40'h06_A1_B2_C3_D4);
        repeat (TO + 4) @(negedge clk);
        check("drop_still_idle", 32'(busy), 32'd0);
        check("drop_txns", 32'(txn_count - txn_before), 32'd1);

        // Reset while the bus request is outstanding
        tx_log.delete();
        resp_en = 1'b0;
        send_write(32'h0000_0050, 32'h0000_0001);
        repeat (3) @(negedge clk);
        check("rst_mid_valid_before", 32'(mem_valid), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("rst_mid_mem_valid", 32'(mem_valid), 32'd0);
        check("rst_mid_mem_addr",  mem_addr,       32'd0);
        check("rst_mid_mem_wdata", mem_wdata,      32'd0);
        check("rst_mid_mem_wstrb", 32'(mem_wstrb), 32'd0);
        check("rst_mid_busy",      32'(busy),      32'd0);
        check("rst_mid_tx_start",  32'(tx_start),  32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (TO + 14) @(negedge clk);
        check("rst_mid_no_stale_tx", 32'(tx_log.size()), 32'd0);
        check("rst_mid_idle",        32'(busy),          32'd0);

        resp_en = 1'b1; resp_delay = 2;
        send_write(32'h0000_0040, 32'hCAFE_F00D);
        wait_idle(200, "post_rst");
        check("post_rst_addr",  cap_addr,        32'h40);
        check("post_rst_wdata", cap_wdata,       32'hCAFE_F00D);
        check("post_rst_wstrb", 32'(cap_wstrb),  32'hF);
        check("post_rst_vlen",  32'(last_vlen),  32'd2);
        check_log("post_rst", 1, 40'h06);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_checks);
        $fatal(1);
    end

endmodule
`default_nettype wire
